// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and redirect-priority helper for the fetch front end.
`default_nettype none

package fetch_pkg;

  localparam int          ADDR_W      = 32;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        redirect;
    logic [31:0] target;
  } redirect_t;

  // Fixed priority jr > branch > jump; targets are always word aligned.
  function automatic redirect_t select_redirect(
    input logic        jr_taken,
    input logic [31:0] jr_addr,
    input logic        branch_taken,
    input logic [31:0] branch_addr,
    input logic        jump_taken,
    input logic [31:0] jump_addr
  );
    redirect_t r;
    r.redirect = jr_taken | branch_taken | jump_taken;
    if (jr_taken) begin
      r.target = jr_addr & WORD_MASK;
    end else if (branch_taken) begin
      r.target = branch_addr & WORD_MASK;
    end else begin
      r.target = jump_addr & WORD_MASK;
    end
    return r;
  endfunction

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// next_pc_sel: combinational redirect detection and prioritised target selection.
`default_nettype none

module next_pc_sel
  import fetch_pkg::*;
(
  input  logic        jr_taken,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump_taken,
  input  logic [31:0] jump_addr,
  output logic        redirect,
  output logic [31:0] target
);

  redirect_t sel;

  always_comb begin
    sel = select_redirect(jr_taken, jr_addr, branch_taken, branch_addr,
                          jump_taken, jump_addr);
    redirect = sel.redirect;
    target   = sel.target;
  end

endmodule : next_pc_sel

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, imem req/ack fetch FSM and IF/ID output buffer.
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jr_taken,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump_taken,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        if_ready
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  req_addr, req_addr_next;
  logic         redirect;
  logic [31:0]  target;
  logic         load_buf;
  logic         clear_buf;

  next_pc_sel u_next_pc_sel (
    .jr_taken     (jr_taken),
    .jr_addr      (jr_addr),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump_taken   (jump_taken),
    .jump_addr    (jump_addr),
    .redirect     (redirect),
    .target       (target)
  );

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_buf   = 1'b0;
    clear_buf  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_next = target;
          end else begin
            load_buf   = 1'b1;
            pc_next    = pc + INSTR_BYTES;
            state_next = ST_HOLD;
          end
        end else if (redirect) begin
          // Request already on the bus must complete before the new target goes out.
          pc_next    = target;
          state_next = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          clear_buf  = 1'b1;
          pc_next    = target;
          state_next = ST_FETCH;
        end else if (if_ready) begin
          clear_buf  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          pc_next = target;
        end
        if (imem_ack) begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
    req_addr_next = (state_next == ST_FETCH) ? pc_next : req_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
    end else if (load_buf) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (clear_buf) begin
      if_valid <= 1'b0;
    end
  end

  assign imem_req    = !rst && ((state == ST_FETCH) || (state == ST_DROP));
  assign imem_addr   = req_addr;
  assign if_pc_plus4 = if_pc + INSTR_BYTES;

endmodule : fetch_pc_unit

`default_nettype wire
